digit_scanner: RTL
==================

# digit_scanner

Time-multiplexed driver for a multi-digit common-signal seven-segment display, sitting directly upstream of `sevenseg`. Holds a packed hex value, scans one digit per refresh tick, and presents the current 4-bit nibble to the single shared `sevenseg` decoder together with a one-hot digit enable. New values are double-buffered and take effect only at a frame boundary, so a digit never shows a mix of old and new values within one frame.

## Interface
- `DIGITS`, 4: number of display digits (2..8).
- `PRESCALE`, 1000: clock cycles per digit slot (≥2).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `load`  in  1  single-cycle strobe; captures `value` on the same edge.
- `value`  in  4*DIGITS  packed nibbles, [3:0] = digit 0 (rightmost, least significant).
- `blank_lz`  in  1  leading-zero blanking enable, sampled every cycle.
- `digit`  out  4  nibble for `sevenseg`; `digit[3]` drives `sevenseg` data[0] (MSB), `digit[0]` drives data[3].
- `an`  out  DIGITS  one-hot digit enable, active-high.
- `blank`  out  1  1 = current digit must be dark (board logic gates segments off).
- `frame_done`  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Registers: prescale counter `cnt` (0..PRESCALE-1), scan index `idx` (0..DIGITS-1), shadow `disp` (displayed value), `pend_val` + `pend` flag (captured but not yet displayed).
- `cnt` increments every cycle; `tick` = (`cnt` == PRESCALE-1), `cnt` wraps to 0 on tick.
- On tick: `idx` <= `idx`+1, wrapping DIGITS-1 -> 0.
- Wrap edge (tick with `idx` == DIGITS-1): if `load` high that cycle, `disp` <= `value` (bypass); else if `pend`, `disp` <= `pend_val`. `pend` <= 0 in both cases.
- `load` outside a wrap edge: `pend_val` <= `value`, `pend` <= 1. Repeated loads: last wins.
- Outputs are combinational from registers only (no input-to-output paths except `blank_lz`): `digit` = `disp` nibble `idx`; `an` = 1 << `idx`.
- `blank` = `blank_lz` AND `idx` != 0 AND nibbles `idx`..DIGITS-1 of `disp` all zero. Digit 0 is never blanked.
- No ready/busy signal: `load` is always accepted.

## Timing
- Reset values: `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_val`=0; hence `an`=0…01, `digit`=0, `blank`=0, `frame_done`=0.
- Each digit is enabled for exactly PRESCALE cycles; frame = DIGITS*PRESCALE cycles.
- `idx` changes on the edge where `cnt` goes PRESCALE-1 -> 0; `an`/`digit` change in the same cycle as `idx`.
- `frame_done` is registered: high for the one cycle following the wrap edge (while `idx`=0, `cnt`=0).
- Load-to-display latency: from the load edge to the next wrap edge, 1..DIGITS*PRESCALE cycles; new value first visible on digit 0 in the cycle `frame_done` is high.
- `reset` asserted mid-frame: all registers clear asynchronously, pending load discarded; scanning restarts from digit 0 with a full PRESCALE slot after release.

## Structure
- Package `display_pkg`: `typedef logic [3:0] nibble_t`, constant `DEFAULT_DIGITS = 4`, constant `DEFAULT_PRESCALE = 1000`.
- One sub-module `tick_gen` (parameter PRESCALE; ports `clk`, `reset`, `tick`): prescale counter only. Scan/buffer logic stays in `digit_scanner`.
- Top-level integration instantiates `digit_scanner` and one `sevenseg`, wiring `digit` to its data input per the bit mapping above.

## Test plan
Use DIGITS=4, PRESCALE=4.
- Reset release, no load -> `an` cycles 0001,0010,0100,1000,0001 every 4 cycles; `digit`=0, `blank`=0; `frame_done` pulses every 16 cycles.
- `load` value=16'h12AF mid-frame -> current frame unchanged (digits 0); after next `frame_done` digits 0..3 show F,A,2,1.
- Two loads in one frame (16'h1111 then 16'h2222) -> only 2,2,2,2 displayed; 1111 never appears.
- `load` 16'h00B0 coincident with wrap edge -> bypass: next frame shows 0,B,0,0 immediately; `pend`=0 afterwards. With `blank_lz`=1 -> `blank`=1 on digits 2,3 only; digit 0 (value 0) not blanked.
- `reset` pulsed mid-frame after a pending `load` 16'hFFFF -> outputs return to reset values asynchronously; subsequent frames show 0000.
- `blank_lz`=1, value 16'h0000 -> `blank`=1 on digits 1..3, 0 on digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and default sizing for the multiplexed seven-segment display path.
package display_pkg;
    typedef logic [3:0] nibble_t;

    localparam int unsigned DEFAULT_DIGITS   = 4;
    localparam int unsigned DEFAULT_PRESCALE = 1000;
endpackage

// File: rtl/tick_gen.sv
// Prescale counter: asserts tick for one cycle every PRESCALE clocks.
module tick_gen
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int unsigned CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/digit_scanner.sv
// Scans a double-buffered packed hex value one digit per slot, driving the shared
// nibble decoder input, a one-hot digit enable and leading-zero blanking.
module digit_scanner
    import display_pkg::*;
#(
    parameter int unsigned DIGITS   = DEFAULT_DIGITS,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     an,
    output logic                  blank,
    output logic                  frame_done
);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                     tick;
    logic                     wrap;
    logic [IW-1:0]            idx;
    nibble_t [DIGITS-1:0]     disp;
    nibble_t [DIGITS-1:0]     pend_val;
    logic                     pend;
    logic                     upper_zero;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign wrap = tick && (idx == IW'(DIGITS - 1));

    // A load on the wrap edge bypasses the pending buffer and lands directly in disp;
    // pend_val is left untouched there because pend is cleared anyway.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            disp       <= '0;
            pend_val   <= '0;
            pend       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick)
                idx <= wrap ? '0 : idx + IW'(1);
            if (wrap) begin
                if (load)
                    disp <= value;
                else if (pend)
                    disp <= pend_val;
                pend <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend     <= 1'b1;
            end
        end
    end

    assign digit = disp[idx];

    always_comb begin
        an      = '0;
        an[idx] = 1'b1;
    end

    always_comb begin
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i >= 32'(idx) && disp[i] != '0)
                upper_zero = 1'b0;
        end
        blank = blank_lz && (idx != '0) && upper_zero;
    end
endmodule
